dm_icb_initiator: RTL
=====================

// Module: dm_icb_initiator
// PURPOSE
//  Hart-side ICB initiator that drives the debug module's i_icb_* target port
//  (debug RAM 0x400-0x43F, debug ROM 0x800-0x8FF). It accepts one host request,
//  issues it as a single ICB command and waits for the ICB response. It then
//  returns rdata plus a status to the host. Used by the core bus and by the
//  verilator bench in place of the tied-off ICB port.
// PARAMETERS
//  AW           12   ICB address width
//  DW           32   ICB data width
//  TIMEOUT_CYC  256  cycles allowed from command issue until the response arrives
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   asynchronous active-low reset
//  host_req_valid   in   1   host request valid
//  host_req_ready   out  1   high only in IDLE
//  host_req_addr    in   AW  byte address; must be word aligned
//  host_req_read    in   1   1=read 0=write
//  host_req_wdata   in   DW  write data
//  host_rsp_valid   out  1   result valid; held until host_rsp_ready
//  host_rsp_ready   in   1   host accepts the result
//  host_rsp_rdata   out  DW  read data (0 on error)
//  host_rsp_err     out  2   00 ok, 01 timeout, 10 misaligned
//  i_icb_cmd_valid  out  1   ICB command valid
//  i_icb_cmd_ready  in   1   DM accepts the command
//  i_icb_cmd_addr   out  AW  ICB address
//  i_icb_cmd_read   out  1   ICB read flag
//  i_icb_cmd_wdata  out  DW  ICB write data
//  i_icb_rsp_valid  in   1   DM response valid
//  i_icb_rsp_ready  out  1   high in IDLE and WAIT
//  i_icb_rsp_rdata  in   DW  DM read data
//  o_stray          out  1   sticky: response seen outside WAIT; cleared only by reset
// BEHAVIOUR
//  - States: IDLE, CMD, WAIT, DONE. Reset (async, rst_n low) forces IDLE.
//    Reset values: cmd_valid=0, host_rsp_valid=0, rdata/err/latched fields=0, o_stray=0.
//    Because the state is IDLE, host_req_ready=1 and i_icb_rsp_ready=1 during and after reset.
//  - IDLE: on host_req_valid, latch addr/read/wdata. If addr[1:0]!=0, go to DONE
//    with err=10 and rdata=0; no ICB traffic. Otherwise go to CMD; clear the timeout counter.
//  - CMD: i_icb_cmd_valid=1. addr/read/wdata come from the latches and are stable
//    while valid is high. The counter increments each cycle. When valid and ready
//    are both high, go to WAIT. A response cannot be accepted in the handshake cycle.
//  - WAIT: the counter keeps running from CMD.
//    * On i_icb_rsp_valid: capture rdata (captured for writes too), err=00, go to DONE.
//    * If the counter reaches TIMEOUT_CYC-1 with no response: err=01, rdata=0, go to DONE.
//    * If the response and the timeout fall in the same cycle, the response wins.
//  - Timeout in CMD: drop cmd_valid (abort), err=01, go to DONE.
//  - DONE: host_rsp_valid=1, with outputs stable. On host_rsp_ready, go to IDLE.
//    host_req_ready=0 in DONE, so one transaction is outstanding at most.
//  - Latency with a zero-wait DM:
//    * request accepted at cycle N, command valid at N+1;
//    * response at N+2 at the earliest, host_rsp_valid at N+3.
//  - A response in IDLE, CMD or DONE is dropped (accepted only in IDLE) and sets o_stray.
//    A late response after a timeout therefore drains harmlessly.
//  - Counter width is $clog2(TIMEOUT_CYC)+1 and it saturates, never wrapping.
//  - Reset in mid-transaction discards all state; the DM side must also be reset.
// STRUCTURE
//  - dm_icb_pkg: state enum, error code localparams (ERR_OK/ERR_TMO/ERR_ALIGN),
//    default AW/DW, and the debug RAM/ROM base addresses.
//  - No sub-module. The FSM, the counter and the request/response registers are inline.
// TESTING
//  1. Write 0x400 = 0xDEADBEEF, then read 0x400:
//     -> both transactions return err=00; the read returns rdata=0xDEADBEEF.
//  2. DM holds cmd_ready low for 5 cycles:
//     -> cmd_valid/addr/wdata stay stable and the transaction completes with err=00.
//  3. Read 0x402:
//     -> host_rsp_valid 1 cycle later, err=10, rdata=0, cmd_valid never asserted.
//  4. Suppress the response (TIMEOUT_CYC=16):
//     -> err=01 at the 16th cycle after issue.
//     A later rsp_valid is dropped and o_stray=1; the next transaction still works.
//  5. host_rsp_ready held low for 10 cycles:
//     -> outputs stay stable and host_req_ready=0 until the result is accepted.
//  6. rst_n pulsed low while in WAIT:
//     -> IDLE immediately, cmd_valid=0, host_rsp_valid=0, o_stray=0.

Source files
------------

// File: rtl/dm_icb_pkg.sv
// Shared types and constants for the hart-side ICB initiator that talks to the
// debug module's i_icb_* target port.
package dm_icb_pkg;

  localparam int DEF_AW = 12;
  localparam int DEF_DW = 32;

  // Debug module address windows as seen on the ICB target port.
  localparam logic [11:0] DM_RAM_BASE = 12'h400;
  localparam logic [11:0] DM_RAM_LAST = 12'h43F;
  localparam logic [11:0] DM_ROM_BASE = 12'h800;
  localparam logic [11:0] DM_ROM_LAST = 12'h8FF;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_TMO   = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/dm_icb_initiator.sv
// Single-outstanding ICB initiator: turns one host request into one ICB command,
// waits (bounded by a timeout) for the response and hands rdata/status back.
module dm_icb_initiator
  import dm_icb_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_req_valid,
  output logic          host_req_ready,
  input  logic [AW-1:0] host_req_addr,
  input  logic          host_req_read,
  input  logic [DW-1:0] host_req_wdata,
  output logic          host_rsp_valid,
  input  logic          host_rsp_ready,
  output logic [DW-1:0] host_rsp_rdata,
  output logic [1:0]    host_rsp_err,
  output logic          i_icb_cmd_valid,
  input  logic          i_icb_cmd_ready,
  output logic [AW-1:0] i_icb_cmd_addr,
  output logic          i_icb_cmd_read,
  output logic [DW-1:0] i_icb_cmd_wdata,
  input  logic          i_icb_rsp_valid,
  output logic          i_icb_rsp_ready,
  input  logic [DW-1:0] i_icb_rsp_rdata,
  output logic          o_stray
);

  localparam int             CW       = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0]  CNT_MAX  = '1;

  state_t        state, state_nxt;
  logic [AW-1:0] addr_q;
  logic          read_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    err_q;
  logic [CW-1:0] cnt;
  logic          stray_q;
  logic          misaligned;
  logic          timed_out;

  assign misaligned = (host_req_addr[1:0] != 2'b00);
  // >= rather than == so a handshake on the very last CMD cycle still times out in WAIT.
  assign timed_out  = (cnt >= CNT_LAST);

  assign i_icb_cmd_addr  = addr_q;
  assign i_icb_cmd_read  = read_q;
  assign i_icb_cmd_wdata = wdata_q;
  assign host_rsp_rdata  = rdata_q;
  assign host_rsp_err    = err_q;
  assign o_stray         = stray_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    host_req_ready  = 1'b0;
    host_rsp_valid  = 1'b0;
    i_icb_cmd_valid = 1'b0;
    i_icb_rsp_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        host_req_ready  = 1'b1;
        i_icb_rsp_ready = 1'b1;
        if (host_req_valid) state_nxt = misaligned ? ST_DONE : ST_CMD;
      end
      ST_CMD: begin
        i_icb_cmd_valid = 1'b1;
        if (i_icb_cmd_ready) state_nxt = ST_WAIT;
        else if (timed_out)  state_nxt = ST_DONE;
      end
      ST_WAIT: begin
        i_icb_rsp_ready = 1'b1;
        if (i_icb_rsp_valid || timed_out) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        host_rsp_valid = 1'b1;
        if (host_rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latches, saturating timeout counter and the result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      read_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (host_req_valid) begin
            addr_q  <= host_req_addr;
            read_q  <= host_req_read;
            wdata_q <= host_req_wdata;
            cnt     <= '0;
            if (misaligned) begin
              err_q   <= ERR_ALIGN;
              rdata_q <= '0;
            end
          end
        end
        ST_CMD: begin
          if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
          if (!i_icb_cmd_ready && timed_out) begin
            err_q   <= ERR_TMO;
            rdata_q <= '0;
          end
        end
        ST_WAIT: begin
          if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
          if (i_icb_rsp_valid) begin
            rdata_q <= i_icb_rsp_rdata;
            err_q   <= ERR_OK;
          end else if (timed_out) begin
            err_q   <= ERR_TMO;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    stray_q <= 1'b0;
    else if (i_icb_rsp_valid && state != ST_WAIT)  stray_q <= 1'b1;
  end

endmodule
